bfm_ahb_cmd_master: RTL and testbench
=====================================

# bfm_ahb_cmd_master

Command-driven AHB-Lite master for the BFM bench; the stage directly upstream of the AHB slave BFM, generating the HSEL-qualified traffic it consumes. It accepts single read/write commands on a valid/ready port and issues them as pipelined SINGLE AHB transfers, overlapping the next address phase with the current data phase. It handles wait states and the two-cycle ERROR response, and returns one response per command.

## Interface
- AWIDTH, 10, HADDR / CMD_ADDR width
- TIMEOUT, 256, consecutive stalled data-phase cycles before abort (only with timeout compiled in); ≥2
- HCLK  in  1  bus clock; all logic on rising edge
- HRESET  in  1  synchronous, active-high reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted on edge where VALID&READY
- CMD_WRITE  in  1  1=write, 0=read
- CMD_ADDR  in  AWIDTH  byte address
- CMD_SIZE  in  3  HSIZE value (0..2 only)
- CMD_WDATA  in  32  write data
- RSP_VALID  out  1  one-cycle pulse, one per command, in command order
- RSP_RDATA  out  32  read data (0 for writes)
- RSP_ERR  out  1  slave ERROR or timeout
- TIMEOUT_FLAG  out  1  sticky, set on any timeout
- HADDR  out  AWIDTH; HTRANS out 2; HWRITE out 1; HSIZE out 3; HBURST out 3 (constant SINGLE); HMASTLOCK out 1 (constant 0); HPROT out 4 (constant 4'b0011); HWDATA out 32
- HREADY  in  1  bus ready; HRESP in 1  1=ERROR; HRDATA in 32

## Operation
- Two register stages: address phase (APH: valid, addr, size, write, wdata) and data phase (DPH: valid, write, wdata).
- CMD_READY = (!APH.valid | HREADY) & state==RUN.
- On edge with HREADY=1 in RUN: DPH completes (response generated if DPH.valid); APH moves to DPH; accepted command (if any) loads APH, else APH.valid=0.
- On edge with HREADY=0: APH and DPH held; address outputs stable.
- HTRANS=NONSEQ when APH.valid & state==RUN, else IDLE. HADDR/HWRITE/HSIZE from APH; HWDATA from DPH.wdata.
- States: RUN, ERR2.
  - RUN→ERR2: DPH.valid & HRESP=1 & HREADY=0 (first error cycle). HTRANS forced IDLE from next cycle.
  - ERR2→RUN: HREADY=1 (second error cycle ends); DPH completes with RSP_ERR=1. Pending APH command is retained, not cancelled, and reissued as NONSEQ in the first RUN cycle.
  - HRESP=1 with HREADY=1 (protocol violation): treated as completing with RSP_ERR=1.
- Responses registered: RSP_VALID/RSP_RDATA (captured HRDATA for reads)/RSP_ERR valid the cycle after completion edge. No backpressure on responses.
- Reset: all outputs 0 (HTRANS=IDLE, HBURST=0, HPROT=4'b0011), APH/DPH invalid, state RUN, TIMEOUT_FLAG=0. Reset mid-transfer abandons everything; no response issued for lost commands.

## Timing
- Command accepted at edge N → NONSEQ on bus cycle N+1 → data phase from N+2 (zero wait) → RSP_VALID in cycle N+3.
- Back-to-back: one command per cycle sustained with HREADY=1; RSP_VALID every cycle.
- Each wait state adds one cycle to all stages.
- Simultaneous: error-first-cycle with CMD_VALID → command not accepted (READY low from ERR2 entry onward, READY still HREADY-gated in the first cycle).

## Configuration
- BFM_AHB_TIMEOUT_EN defined: stall counter counts consecutive DPH cycles with HREADY=0; reaching TIMEOUT completes DPH with RSP_ERR=1, sets TIMEOUT_FLAG, forces state RUN; counter clears on any HREADY=1.
- Undefined: no counter; stalls wait indefinitely; TIMEOUT_FLAG tied 0; TIMEOUT ignored.

## Structure
- Package bfm_ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HBURST_SINGLE, HPROT_DEFAULT, state enum {RUN, ERR2}.
- Sub-module bfm_ahb_stall_timer (counter + terminal pulse), instantiated only under BFM_AHB_TIMEOUT_EN.

## Test plan
- Write 0x0A0 data 0xDEADBEEF, HREADY=1 → NONSEQ HWRITE=1 HADDR=0x0A0 cycle 1, HWDATA=0xDEADBEEF cycle 2, RSP_VALID RSP_ERR=0 cycle 3.
- Read 0x004 with slave HRDATA=0x12345678 → RSP_RDATA=0x12345678, RSP_ERR=0.
- 4 back-to-back writes 0x000..0x00C, HREADY=1 → four consecutive NONSEQ cycles, four consecutive RSP_VALID pulses in order.
- Read with 3 wait states → address held, RSP_VALID 3 cycles later than zero-wait case; next queued command's HADDR unchanged during stall.
- Write 0x010 answered ERROR (HRESP=1 two cycles) with read 0x014 pending → HTRANS IDLE in second error cycle, RSP_ERR=1 for write, read reissued and completes RSP_ERR=0.
- BFM_AHB_TIMEOUT_EN, TIMEOUT=8, HREADY held 0 → RSP_ERR=1 after 8 stall cycles, TIMEOUT_FLAG=1 until HRESET.

Source files
------------

// File: rtl/bfm_ahb_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the command-driven AHB master.
package bfm_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  typedef enum logic {
    RUN  = 1'b0,
    ERR2 = 1'b1
  } state_t;

endpackage

// File: rtl/bfm_ahb_stall_timer.sv
// Counts consecutive stalled data-phase cycles; expire pulses on the LIMIT-th stalled cycle.
module bfm_ahb_stall_timer #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic expire
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  assign expire = stall && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || !stall || expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/bfm_ahb_cmd_master.sv
// Command-driven AHB-Lite master issuing pipelined SINGLE transfers, one response per command.
// Optional data-phase stall timeout is compiled in with BFM_AHB_TIMEOUT_EN.
module bfm_ahb_cmd_master
  import bfm_ahb_pkg::*;
#(
  parameter int AWIDTH  = 10,
  parameter int TIMEOUT = 256
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [2:0]        CMD_SIZE,
  input  logic [31:0]       CMD_WDATA,
  output logic              RSP_VALID,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERR,
  output logic              TIMEOUT_FLAG,
  output logic [AWIDTH-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [31:0]       HRDATA,
  output state_t            dbg_state
);

  // Handshake: a command transfers on each rising edge where CMD_VALID && CMD_READY;
  // the source holds the command stable until then. RSP_VALID is a one-cycle pulse, never stalled.

  state_t state, state_nx;

  logic              aph_valid;
  logic [AWIDTH-1:0] aph_addr;
  logic [2:0]        aph_size;
  logic              aph_write;
  logic [31:0]       aph_wdata;
  logic              dph_valid;
  logic              dph_write;
  logic [31:0]       dph_wdata;

  logic accept;
  logic advance;
  logic complete;
  logic complete_err;
  logic timeout_hit;

`ifdef BFM_AHB_TIMEOUT_EN
  logic stall;
  assign stall = dph_valid && !HREADY;

  bfm_ahb_stall_timer #(.LIMIT(TIMEOUT)) u_stall_timer (
    .clk    (HCLK),
    .rst    (HRESET),
    .stall  (stall),
    .expire (timeout_hit)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      TIMEOUT_FLAG <= 1'b0;
    end else if (timeout_hit) begin
      TIMEOUT_FLAG <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 1);
  assign timeout_hit    = 1'b0;
  assign TIMEOUT_FLAG   = 1'b0;
`endif

  always_comb begin
    CMD_READY    = (!aph_valid || HREADY) && (state == RUN);
    accept       = CMD_VALID && CMD_READY;
    state_nx     = state;
    advance      = 1'b0;
    complete     = 1'b0;
    // An abort, a second error cycle and an ERROR seen with HREADY high all report as errors.
    complete_err = HRESP || timeout_hit || (state == ERR2);
    if (timeout_hit) begin
      complete = dph_valid;
      state_nx = RUN;
    end else begin
      case (state)
        RUN: begin
          if (HREADY) begin
            complete = dph_valid;
            advance  = 1'b1;
          end else if (dph_valid && HRESP) begin
            state_nx = ERR2;
          end
        end
        ERR2: begin
          if (HREADY) begin
            complete = dph_valid;
            state_nx = RUN;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= RUN;
      aph_valid <= 1'b0;
      aph_addr  <= '0;
      aph_size  <= '0;
      aph_write <= 1'b0;
      aph_wdata <= '0;
      dph_valid <= 1'b0;
      dph_write <= 1'b0;
      dph_wdata <= '0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= 1'b0;
    end else begin
      state     <= state_nx;
      RSP_VALID <= complete;
      RSP_ERR   <= complete && complete_err;
      RSP_RDATA <= (complete && !dph_write) ? HRDATA : 32'h0;
      if (complete) begin
        dph_valid <= 1'b0;
      end
      if (advance) begin
        dph_valid <= aph_valid;
        dph_write <= aph_write;
        dph_wdata <= aph_wdata;
      end
      // APH can also fill during a stall when it was empty; the bus has not sampled it yet.
      if (accept) begin
        aph_valid <= 1'b1;
        aph_addr  <= CMD_ADDR;
        aph_size  <= CMD_SIZE;
        aph_write <= CMD_WRITE;
        aph_wdata <= CMD_WDATA;
      end else if (advance) begin
        aph_valid <= 1'b0;
      end
    end
  end

  assign HTRANS    = (aph_valid && state == RUN) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = aph_addr;
  assign HWRITE    = aph_write;
  assign HSIZE     = aph_size;
  assign HWDATA    = dph_wdata;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_DEFAULT;
  assign dbg_state = state;

endmodule

// File: tb/tb_bfm_ahb_cmd_master.sv
// Self-checking bench for bfm_ahb_cmd_master: directed vectors, corner sequences, random traffic
// against a transaction-level slave/scoreboard model. Timeout cases follow BFM_AHB_TIMEOUT_EN.
module tb_bfm_ahb_cmd_master;
  import bfm_ahb_pkg::*;

  localparam int AW = 10;
  localparam int TO = 8;

  logic          HCLK, HRESET;
  logic          CMD_VALID, CMD_READY, CMD_WRITE;
  logic [AW-1:0] CMD_ADDR;
  logic [2:0]    CMD_SIZE;
  logic [31:0]   CMD_WDATA;
  logic          RSP_VALID, RSP_ERR, TIMEOUT_FLAG;
  logic [31:0]   RSP_RDATA;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE, HMASTLOCK;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;
  logic [31:0]   HWDATA, HRDATA;
  logic          HREADY, HRESP;
  state_t        dbg_state;

  bfm_ahb_cmd_master #(.AWIDTH(AW), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
    .CMD_ADDR(CMD_ADDR), .CMD_SIZE(CMD_SIZE), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .TIMEOUT_FLAG(TIMEOUT_FLAG),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic v, input logic w, input logic [AW-1:0] a,
                           input logic [2:0] s, input logic [31:0] d);
    CMD_VALID = v;
    CMD_WRITE = w;
    CMD_ADDR  = a;
    CMD_SIZE  = s;
    CMD_WDATA = d;
  endtask

  task automatic slave(input logic rdy, input logic resp, input logic [31:0] rd);
    HREADY = rdy;
    HRESP  = resp;
    HRDATA = rd;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    drive_cmd(1'b0, 1'b0, '0, 3'd0, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    tick();
    tick();
    HRESET = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {a, 6'h15, ~a, 6'h2A};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [31:0]   wdata;
    logic [31:0]   slave_rdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  vec_t vecs[6];

  // ---------------- random model / scoreboard ----------------
  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [31:0]   wdata;
  } cmd_t;

  cmd_t        acc_q[$];
  logic [33:0] exp_q[$];   // {check_rdata, err, rdata}

  initial begin
    cmd_t        cur_cmd, dp_cmd, c;
    logic        have_cmd, dp_valid, rsp_due, e_err;
    int          dp_wait, dp_kind, dp_phase, r, n_acc, n_rsp;
    logic        s_cmd_valid, s_cmd_ready, s_hready, s_hresp, s_hwrite;
    logic [1:0]  s_htrans;
    logic [AW-1:0] s_haddr;
    logic [2:0]  s_hsize;
    logic [31:0] s_hwdata;
    logic [33:0] e;
    int          stall_rsp_cyc;
    logic        stall_err, to_build;

`ifdef BFM_AHB_TIMEOUT_EN
    stall_rsp_cyc = 2 + TO;
    stall_err     = 1'b1;
    to_build      = 1'b1;
`else
    stall_rsp_cyc = 23;
    stall_err     = 1'b0;
    to_build      = 1'b0;
`endif

    vecs[0] = '{1'b1, 10'h0A0, 3'd2, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0};
    vecs[1] = '{1'b0, 10'h004, 3'd2, 32'h00000000, 32'h12345678, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 10'h3FF, 3'd0, 32'h000000A5, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[3] = '{1'b0, 10'h3FE, 3'd1, 32'h00000000, 32'h0000BEEF, 32'h0000BEEF, 1'b0};
    vecs[4] = '{1'b0, 10'h000, 3'd0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{1'b1, 10'h200, 3'd1, 32'h1234ABCD, 32'h55AA55AA, 32'h00000000, 1'b0};

    HRESET = 1'b1;
    drive_cmd(1'b0, 1'b0, '0, 3'd0, 32'h0);
    slave(1'b1, 1'b0, 32'h0);

    // ---- reset values ----
    tick();
    tick();
    chk("rst_htrans", HTRANS, HTRANS_IDLE);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", HWRITE, 0);
    chk("rst_hsize", HSIZE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_hburst", HBURST, 0);
    chk("rst_hmastlock", HMASTLOCK, 0);
    chk("rst_hprot", HPROT, 4'b0011);
    chk("rst_rsp", {RSP_VALID, RSP_ERR, RSP_RDATA}, 0);
    chk("rst_tflag", TIMEOUT_FLAG, 0);
    chk("rst_state", dbg_state, RUN);
    HRESET = 1'b0;
    tick();

    // ---- single zero-wait commands from the table ----
    for (int i = 0; i < 6; i++) begin
      drive_cmd(1'b1, vecs[i].write, vecs[i].addr, vecs[i].size, vecs[i].wdata);
      slave(1'b1, 1'b0, 32'hBAD0BAD0);
      #1;
      chk("vec_ready", CMD_READY, 1);
      tick();
      drive_cmd(1'b0, 1'b0, '0, 3'd0, 32'h0);
      #1;
      chk("vec_aph", {HTRANS, HWRITE, HADDR, HSIZE},
          {HTRANS_NONSEQ, vecs[i].write, vecs[i].addr, vecs[i].size});
      tick();
      HRDATA = vecs[i].slave_rdata;
      #1;
      chk("vec_dph_idle", HTRANS, HTRANS_IDLE);
      if (vecs[i].write) chk("vec_hwdata", HWDATA, vecs[i].wdata);
      chk("vec_no_early_rsp", RSP_VALID, 0);
      tick();
      HRDATA = 32'hBAD0BAD0;
      #1;
      chk("vec_rsp_valid", RSP_VALID, 1);
      chk("vec_rsp_rdata", RSP_RDATA, vecs[i].exp_rdata);
      chk("vec_rsp_err", RSP_ERR, vecs[i].exp_err);
      tick();
      #1;
      chk("vec_rsp_pulse", RSP_VALID, 0);
    end

    // ---- four back-to-back writes ----
    for (int cy = 0; cy < 8; cy++) begin
      if (cy < 4) drive_cmd(1'b1, 1'b1, AW'(4 * cy), 3'd2, 32'hB0B00000 + cy);
      else        drive_cmd(1'b0, 1'b0, '0, 3'd0, 32'h0);
      slave(1'b1, 1'b0, 32'h0);
      #1;
      if (cy < 4) chk("b2b_ready", CMD_READY, 1);
      if (cy >= 1 && cy <= 4) chk("b2b_aph", {HTRANS, HADDR}, {HTRANS_NONSEQ, AW'(4 * (cy - 1))});
      if (cy >= 2 && cy <= 5) chk("b2b_hwdata", HWDATA, 32'hB0B00000 + cy - 2);
      chk("b2b_rsp_valid", RSP_VALID, (cy >= 3 && cy <= 6));
      tick();
    end

    // ---- read with three wait states, next commands queued ----
    for (int cy = 0; cy < 10; cy++) begin
      case (cy)
        0: drive_cmd(1'b1, 1'b0, 10'h040, 3'd2, 32'h0);
        1: drive_cmd(1'b1, 1'b1, 10'h044, 3'd2, 32'h44444444);
        2: drive_cmd(1'b1, 1'b1, 10'h048, 3'd2, 32'h48484848);
        6: drive_cmd(1'b0, 1'b0, '0, 3'd0, 32'h0);
        default: ;
      endcase
      if (cy >= 2 && cy <= 4) slave(1'b0, 1'b0, 32'hBAADBAAD);
      else if (cy == 5)       slave(1'b1, 1'b0, 32'h13579BDF);
      else                    slave(1'b1, 1'b0, 32'hBAADBAAD);
      #1;
      if (cy >= 2 && cy <= 5) begin
        chk("ws_held_aph", {HTRANS, HADDR}, {HTRANS_NONSEQ, 10'h044});
        chk("ws_ready", CMD_READY, (cy == 5));
      end
      if (cy == 6) chk("ws_next_aph", {HTRANS, HADDR, HWDATA}, {HTRANS_NONSEQ, 10'h048, 32'h44444444});
      if (cy == 7) chk("ws_last_hwdata", HWDATA, 32'h48484848);
      chk("ws_rsp_valid", RSP_VALID, (cy >= 6 && cy <= 8));
      if (cy == 6) chk("ws_rsp_rdata", {RSP_ERR, RSP_RDATA}, {1'b0, 32'h13579BDF});
      if (cy == 7 || cy == 8) chk("ws_rsp_wr", {RSP_ERR, RSP_RDATA}, 0);
      tick();
    end

    // ---- write answered ERROR with a read pending ----
    for (int cy = 0; cy < 9; cy++) begin
      case (cy)
        0: drive_cmd(1'b1, 1'b1, 10'h010, 3'd2, 32'h11112222);
        1: drive_cmd(1'b1, 1'b0, 10'h014, 3'd2, 32'h0);
        2: drive_cmd(1'b1, 1'b1, 10'h018, 3'd2, 32'h18181818);
        5: drive_cmd(1'b0, 1'b0, '0, 3'd0, 32'h0);
        default: ;
      endcase
      if (cy == 2)      slave(1'b0, 1'b1, 32'h0);
      else if (cy == 3) slave(1'b1, 1'b1, 32'h0);
      else if (cy == 5) slave(1'b1, 1'b0, 32'h0F0F0F0F);
      else              slave(1'b1, 1'b0, 32'hBAADBAAD);
      #1;
      if (cy == 2) chk("err1_ready", CMD_READY, 0);
      if (cy == 3) begin
        chk("err2_state", dbg_state, ERR2);
        chk("err2_htrans_idle", HTRANS, HTRANS_IDLE);
        chk("err2_ready", CMD_READY, 0);
      end
      if (cy == 4) begin
        chk("err_reissue", {HTRANS, HWRITE, HADDR}, {HTRANS_NONSEQ, 1'b0, 10'h014});
        chk("err_rsp", {RSP_VALID, RSP_ERR}, 2'b11);
      end
      if (cy == 5) chk("err_after_aph", {HTRANS, HADDR}, {HTRANS_NONSEQ, 10'h018});
      if (cy == 6) chk("err_after_hwdata", HWDATA, 32'h18181818);
      chk("err_rsp_valid", RSP_VALID, (cy == 4 || cy == 6 || cy == 7));
      if (cy == 6) chk("err_read_rsp", {RSP_ERR, RSP_RDATA}, {1'b0, 32'h0F0F0F0F});
      if (cy == 7) chk("err_write_rsp", {RSP_ERR, RSP_RDATA}, 0);
      tick();
    end

    // ---- long stall: timeout abort when compiled in, otherwise waits ----
    for (int cy = 0; cy < 26; cy++) begin
      if (cy == 0) drive_cmd(1'b1, 1'b0, 10'h020, 3'd2, 32'h0);
      else         drive_cmd(1'b0, 1'b0, '0, 3'd0, 32'h0);
      if (cy >= 2 && cy <= 21) slave(1'b0, 1'b0, 32'hBAADBAAD);
      else if (cy == 22)       slave(1'b1, 1'b0, 32'h7E57DA7A);
      else                     slave(1'b1, 1'b0, 32'hBAADBAAD);
      #1;
      chk("stall_rsp_valid", RSP_VALID, (cy == stall_rsp_cyc));
      if (cy == stall_rsp_cyc) begin
        chk("stall_rsp_err", RSP_ERR, stall_err);
        if (!stall_err) chk("stall_rsp_rdata", RSP_RDATA, 32'h7E57DA7A);
      end
      chk("stall_tflag", TIMEOUT_FLAG, (to_build && cy >= 2 + TO));
      tick();
    end

    // ---- reset in the middle of a transfer ----
    drive_cmd(1'b1, 1'b0, 10'h0C0, 3'd2, 32'h0);
    slave(1'b1, 1'b0, 32'h0);
    tick();
    drive_cmd(1'b0, 1'b0, '0, 3'd0, 32'h0);
    tick();
    HRESET = 1'b1;
    slave(1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("midrst_htrans", HTRANS, HTRANS_IDLE);
    chk("midrst_tflag", TIMEOUT_FLAG, 0);
    HRESET = 1'b0;
    slave(1'b1, 1'b0, 32'h0);
    for (int cy = 0; cy < 4; cy++) begin
      #1;
      chk("midrst_no_rsp", {RSP_VALID, HTRANS}, {1'b0, HTRANS_IDLE});
      tick();
    end

    // ---- random traffic against the transaction-level model ----
    do_reset();
    have_cmd = 1'b0; dp_valid = 1'b0; dp_wait = 0; dp_kind = 0; dp_phase = 0;
    n_acc = 0; n_rsp = 0;
    cur_cmd = '0; dp_cmd = '0;
    s_cmd_valid = 1'b0; s_cmd_ready = 1'b0; s_hready = 1'b0; s_hresp = 1'b0;
    s_htrans = HTRANS_IDLE; s_haddr = '0; s_hwrite = 1'b0; s_hsize = '0; s_hwdata = '0;
    for (int cyc = 0; cyc < 2400; cyc++) begin
      // effects of the edge just taken, from values held stable before it
      rsp_due = 1'b0;
      if (s_hready) begin
        if (dp_valid) begin
          if (dp_cmd.write) chk("rnd_hwdata", s_hwdata, dp_cmd.wdata);
          e_err = (dp_kind != 0);
          exp_q.push_back({!e_err && !dp_cmd.write, e_err,
                           dp_cmd.write ? 32'h0 : mem_word(dp_cmd.addr)});
          rsp_due  = 1'b1;
          dp_valid = 1'b0;
        end
        if (s_htrans == HTRANS_NONSEQ) begin
          if (acc_q.size() == 0) begin
            chk("rnd_unexpected_nonseq", 1, 0);
          end else begin
            c = acc_q.pop_front();
            chk("rnd_addr_phase", {s_hwrite, s_haddr, s_hsize}, {c.write, c.addr, c.size});
            dp_valid = 1'b1;
            dp_cmd   = c;
            dp_wait  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            r        = $urandom_range(0, 15);
            dp_kind  = (r < 2) ? 1 : ((r == 2) ? 2 : 0);
            dp_phase = 0;
          end
        end
      end else if (dp_valid) begin
        if (dp_wait > 0) dp_wait--;
        else if (dp_kind == 1) dp_phase = 1;
      end
      if (s_cmd_valid && s_cmd_ready) begin
        acc_q.push_back(cur_cmd);
        have_cmd = 1'b0;
        n_acc++;
      end

      // drive this cycle
      if (!have_cmd && cyc < 2000 && $urandom_range(0, 3) != 0) begin
        cur_cmd.write = 1'($urandom_range(0, 1));
        cur_cmd.addr  = AW'($urandom);
        cur_cmd.size  = 3'($urandom_range(0, 2));
        cur_cmd.wdata = $urandom;
        have_cmd      = 1'b1;
      end
      drive_cmd(have_cmd, cur_cmd.write, cur_cmd.addr, cur_cmd.size, cur_cmd.wdata);
      if (dp_valid && dp_wait > 0)  slave(1'b0, 1'b0, $urandom);
      else if (dp_valid && dp_kind == 1) slave(dp_phase != 0, 1'b1, $urandom);
      else if (dp_valid && dp_kind == 2) slave(1'b1, 1'b1, $urandom);
      else if (dp_valid && !dp_cmd.write) slave(1'b1, 1'b0, mem_word(dp_cmd.addr));
      else slave(1'b1, 1'b0, $urandom);
      #1;

      s_cmd_valid = CMD_VALID; s_cmd_ready = CMD_READY;
      s_hready = HREADY; s_hresp = HRESP;
      s_htrans = HTRANS; s_haddr = HADDR; s_hwrite = HWRITE; s_hsize = HSIZE; s_hwdata = HWDATA;
      if (HTRANS != HTRANS_IDLE && HTRANS != HTRANS_NONSEQ) chk("rnd_htrans_legal", HTRANS, HTRANS_NONSEQ);
      if (RSP_VALID || rsp_due) begin
        chk("rnd_rsp_timing", RSP_VALID, rsp_due);
        if (rsp_due) begin
          e = exp_q.pop_front();
          n_rsp++;
          if (RSP_VALID) begin
            chk("rnd_rsp_err", RSP_ERR, e[32]);
            if (e[33]) chk("rnd_rsp_rdata", RSP_RDATA, e[31:0]);
          end
        end
      end
      tick();
    end
    chk("rnd_all_accepted", have_cmd, 0);
    chk("rnd_rsp_count", n_rsp, n_acc);
    chk("rnd_acc_q_empty", acc_q.size(), 0);
    chk("rnd_traffic", (n_acc > 200), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
